seq_rem: RTL

//  Parametrised, multi-cycle unsigned remainder unit, successor to the 3-bit

---
 rtl/seq_rem_pkg.sv | 13 +
 rtl/seq_rem_step.sv | 24 ++
 rtl/seq_rem.sv | 132 +++++++++++++
 3 files changed

// File: rtl/seq_rem_pkg.sv
// Shared types and defaults for the sequential remainder unit.
// Holds the FSM state encoding and the default operand width.
package seq_rem_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    localparam int SEQ_REM_WIDTH_DEF = 8;

endpackage

// File: rtl/seq_rem_step.sv
// One radix-2 restoring step: shift a dividend bit into the partial
// remainder and subtract the divisor when it fits.
// Ports: p (partial rem), qbit (next dividend bit), d (divisor) ->
//        p_next (new partial rem), q_next (quotient bit).
module seq_rem_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] p,
    input  logic             qbit,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] p_next,
    output logic             q_next
);

    logic [WIDTH:0] t;
    logic [WIDTH:0] diff;

    // One extra MSB so the shifted partial remainder never overflows.
    assign t      = {p, qbit};
    assign diff   = t - {1'b0, d};
    assign q_next = (t >= {1'b0, d});
    assign p_next = q_next ? diff[WIDTH-1:0] : t[WIDTH-1:0];

endmodule

// File: rtl/seq_rem.sv
// Multi-cycle unsigned remainder (numerator % denominator), one bit per clock.
// Ports: clk, rst_n (async active-low), start, numerator, denominator in;
//        ready, busy, done, remainder, divbyzero out; quotient out only
//        when SEQ_REM_QUOTIENT_EN is defined.
module seq_rem
    import seq_rem_pkg::*;
#(
    parameter int WIDTH = SEQ_REM_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] numerator,
    input  logic [WIDTH-1:0] denominator,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] remainder,
    output logic             divbyzero
`ifdef SEQ_REM_QUOTIENT_EN
    ,
    output logic [WIDTH-1:0] quotient
`endif
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] cnt;
    logic [WIDTH-1:0] p_q;
    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] d_q;
    logic [WIDTH-1:0] rem_q;
    logic             dz_q;
    logic [WIDTH-1:0] p_next;
    logic             q_next;
    logic             accept;
    logic             last;
`ifdef SEQ_REM_QUOTIENT_EN
    logic [WIDTH-1:0] quo_q;
`endif

    seq_rem_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .p      (p_q),
        .qbit   (q_q[WIDTH-1]),
        .d      (d_q),
        .p_next (p_next),
        .q_next (q_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        ready      = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        last       = 1'b0;
        unique case (state)
            S_IDLE: begin
                ready  = 1'b1;
                accept = start;
                if (start)
                    state_next = (denominator == '0) ? S_DONE : S_CALC;
            end
            S_CALC: begin
                busy = 1'b1;
                last = (cnt == CNT_W'(1));
                if (last) state_next = S_DONE;
            end
            S_DONE: begin
                busy       = 1'b1;
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt   <= '0;
            p_q   <= '0;
            q_q   <= '0;
            d_q   <= '0;
            rem_q <= '0;
            dz_q  <= 1'b0;
        end else if (accept) begin
            cnt <= CNT_W'(WIDTH);
            p_q <= '0;
            q_q <= numerator;
            d_q <= denominator;
            // Zero divisor skips CALC; result is published right away.
            if (denominator == '0) begin
                rem_q <= numerator;
                dz_q  <= 1'b1;
            end
        end else if (state == S_CALC) begin
            cnt <= cnt - CNT_W'(1);
            p_q <= p_next;
            q_q <= {q_q[WIDTH-2:0], q_next};
            if (last) begin
                rem_q <= p_next;
                dz_q  <= 1'b0;
            end
        end
    end

`ifdef SEQ_REM_QUOTIENT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            quo_q <= '0;
        else if (accept && denominator == '0)
            quo_q <= '1;
        else if (state == S_CALC && last)
            quo_q <= {q_q[WIDTH-2:0], q_next};
    end

    assign quotient = quo_q;
`endif

    assign remainder = rem_q;
    assign divbyzero = dz_q;

endmodule
